// File: rtl/dht11_sequencer_pkg.sv
// Shared types and helpers for the DHT11 measurement sequencer.
package dht11_sequencer_pkg;

   // Sequencer states; also exported on the debug port of the top level.
   typedef enum logic [2:0] {
      ST_POWERUP   = 3'd0,
      ST_IDLE      = 3'd1,
      ST_TRIG      = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_CONVERT   = 3'd4,
      ST_PUBLISH   = 3'd5
   } state_t;

   localparam int MS_PER_S    = 1000;
   localparam int BIN_W       = 8;
   localparam int BCD_DIGIT_W = 4;
   localparam int BCD_DIGITS  = 3;
   localparam int BCD_W       = BCD_DIGITS * BCD_DIGIT_W;
   localparam int DD_SR_W     = BCD_W + BIN_W;

   // One double-dabble iteration on {bcd, bin}: add 3 to any digit >= 5, then shift left.
   function automatic logic [DD_SR_W-1:0] dd_step(input logic [DD_SR_W-1:0] sr);
      logic [DD_SR_W-1:0] t;
      t = sr;
      for (int d = 0; d < BCD_DIGITS; d++) begin
         if (t[BIN_W + d*BCD_DIGIT_W +: BCD_DIGIT_W] >= 4'd5) begin
            t[BIN_W + d*BCD_DIGIT_W +: BCD_DIGIT_W] = t[BIN_W + d*BCD_DIGIT_W +: BCD_DIGIT_W] + 4'd3;
         end
      end
      return {t[DD_SR_W-2:0], 1'b0};
   endfunction

endpackage

// File: rtl/dht11_sequencer_bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-add-3, one bit per cycle).
// i_start loads the operand; o_done pulses for one cycle 8 clocks later with o_bcd final.
module bin2bcd_seq
   import dht11_sequencer_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [BIN_W-1:0] i_bin,
   output logic [BCD_W-1:0] o_bcd,
   output logic             o_done
);

   logic [DD_SR_W-1:0] r_sr;
   logic [3:0]         r_cnt;
   logic               r_busy;
   logic               r_done;

   // Load on start, then apply one double-dabble step per cycle for BIN_W cycles.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sr   <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (i_start) begin
            r_sr   <= {{BCD_W{1'b0}}, i_bin};
            r_cnt  <= '0;
            r_busy <= 1'b1;
         end else if (r_busy) begin
            r_sr  <= dd_step(r_sr);
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == 4'(BIN_W - 1)) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end
         end
      end
   end

   assign o_bcd  = r_sr[DD_SR_W-1:BIN_W];
   assign o_done = r_done;

endmodule

// File: rtl/dht11_sequencer.sv
// Periodic DHT11 measurement sequencer: triggers dht11_controller, enforces power-up delay,
// sample spacing and response timeout, keeps last good integer bytes plus their BCD form.
// Handshake: o_dht_start and i_dht_done are single-cycle pulses; i_dht_valid is only
// meaningful in the cycle i_dht_done is high; i_force_req is a single-cycle request.
module dht11_sequencer
   import dht11_sequencer_pkg::*;
#(
   parameter int CLK_HZ     = 100_000_000,
   parameter int POWERUP_MS = 1000,
   parameter int PERIOD_MS  = 2000,
   parameter int MIN_GAP_MS = 1000,
   parameter int TIMEOUT_MS = 30
)(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_enable,
   input  logic             i_force_req,
   input  logic             i_dht_done,
   input  logic             i_dht_valid,
   input  logic [15:0]      i_dht_humidity,
   input  logic [15:0]      i_dht_temperature,
   output logic             o_dht_start,
   output logic [7:0]       o_hum_int,
   output logic [7:0]       o_temp_int,
   output logic [BCD_W-1:0] o_hum_bcd,
   output logic [BCD_W-1:0] o_temp_bcd,
   output logic             o_data_valid,
   output logic             o_update,
   output logic             o_err_timeout,
   output logic             o_err_checksum,
   output logic [7:0]       o_err_cnt,
   output logic             o_busy,
   output state_t           o_dbg_state
);

   localparam int MS_DIV = CLK_HZ / MS_PER_S;
   localparam int DIV_W  = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
   localparam int EL_MAX = (PERIOD_MS > MIN_GAP_MS) ? PERIOD_MS : MIN_GAP_MS;
   localparam int EL_W   = $clog2(EL_MAX + 1);
   localparam int PU_W   = $clog2(POWERUP_MS + 1);
   localparam int TO_W   = $clog2(TIMEOUT_MS + 1);

   state_t            r_state;
   logic [DIV_W-1:0]  r_div;
   logic [PU_W-1:0]   r_pu;
   logic [EL_W-1:0]   r_el;
   logic [TO_W-1:0]   r_to;
   logic              r_force_pend;
   logic              r_start;
   logic [7:0]        r_hum_sh, r_temp_sh;
   logic [7:0]        r_hum_int, r_temp_int;
   logic [BCD_W-1:0]  r_hum_bcd, r_temp_bcd;
   logic              r_data_valid, r_update, r_err_to, r_err_cs, r_busy;
   logic [7:0]        r_err_cnt;

   logic              w_ms_tick;
   logic              w_bcd_start;
   logic [BCD_W-1:0]  w_hum_bcd, w_temp_bcd;
   logic              w_hum_done, w_temp_done;
   logic              w_unused;

   // Fractional bytes are not used by this layer.
   assign w_unused = ^{i_dht_humidity[7:0], i_dht_temperature[7:0]};

   assign w_ms_tick = (r_div == DIV_W'(MS_DIV - 1));

   // Converters start straight from the controller bytes so publish lands 10 cycles after done.
   assign w_bcd_start = (r_state == ST_WAIT_DONE) && i_dht_done && i_dht_valid;

   // Free-running millisecond divider.
   always_ff @(posedge i_clk) begin
      if (i_rst || w_ms_tick) r_div <= '0;
      else                    r_div <= r_div + DIV_W'(1);
   end

   // A forced request stays pending until the trigger that services it.
   always_ff @(posedge i_clk) begin
      if (i_rst)                     r_force_pend <= 1'b0;
      else if (i_force_req)          r_force_pend <= 1'b1;
      else if (r_state == ST_TRIG)   r_force_pend <= 1'b0;
   end

   bin2bcd_seq u_hum_bcd (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_start (w_bcd_start),
      .i_bin   (i_dht_humidity[15:8]),
      .o_bcd   (w_hum_bcd),
      .o_done  (w_hum_done)
   );

   bin2bcd_seq u_temp_bcd (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_start (w_bcd_start),
      .i_bin   (i_dht_temperature[15:8]),
      .o_bcd   (w_temp_bcd),
      .o_done  (w_temp_done)
   );

   // Sequencer FSM with all data, status and strobe outputs registered.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= ST_POWERUP;
         r_pu         <= '0;
         r_el         <= '0;
         r_to         <= '0;
         r_start      <= 1'b0;
         r_hum_sh     <= '0;
         r_temp_sh    <= '0;
         r_hum_int    <= '0;
         r_temp_int   <= '0;
         r_hum_bcd    <= '0;
         r_temp_bcd   <= '0;
         r_data_valid <= 1'b0;
         r_update     <= 1'b0;
         r_err_to     <= 1'b0;
         r_err_cs     <= 1'b0;
         r_err_cnt    <= '0;
         r_busy       <= 1'b0;
      end else begin
         r_start  <= 1'b0;
         r_update <= 1'b0;
         // Time since last start keeps running through the whole transaction; TRIG zeroes it.
         if (w_ms_tick && (r_state != ST_POWERUP) && (r_el != EL_W'(EL_MAX))) begin
            r_el <= r_el + EL_W'(1);
         end
         case (r_state)
            ST_POWERUP: begin
               if (w_ms_tick) begin
                  if (r_pu == PU_W'(POWERUP_MS - 1)) begin
                     r_state <= ST_IDLE;
                     r_el    <= EL_W'(PERIOD_MS);
                  end else begin
                     r_pu <= r_pu + PU_W'(1);
                  end
               end
            end
            ST_IDLE: begin
               if ((i_enable && (r_el >= EL_W'(PERIOD_MS))) ||
                   (r_force_pend && (r_el >= EL_W'(MIN_GAP_MS)))) begin
                  r_state <= ST_TRIG;
                  r_start <= 1'b1;
                  r_busy  <= 1'b1;
               end
            end
            ST_TRIG: begin
               r_el    <= '0;
               r_to    <= '0;
               r_state <= ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
               if (i_dht_done) begin
                  if (i_dht_valid) begin
                     r_hum_sh  <= i_dht_humidity[15:8];
                     r_temp_sh <= i_dht_temperature[15:8];
                     r_state   <= ST_CONVERT;
                  end else begin
                     r_err_cs <= 1'b1;
                     r_err_to <= 1'b0;
                     if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
                     r_state  <= ST_IDLE;
                     r_busy   <= 1'b0;
                  end
               end else if (w_ms_tick) begin
                  if (r_to == TO_W'(TIMEOUT_MS - 1)) begin
                     r_err_to <= 1'b1;
                     r_err_cs <= 1'b0;
                     if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
                     r_state  <= ST_IDLE;
                     r_busy   <= 1'b0;
                  end else begin
                     r_to <= r_to + TO_W'(1);
                  end
               end
            end
            ST_CONVERT: begin
               if (w_hum_done && w_temp_done) begin
                  r_hum_int    <= r_hum_sh;
                  r_temp_int   <= r_temp_sh;
                  r_hum_bcd    <= w_hum_bcd;
                  r_temp_bcd   <= w_temp_bcd;
                  r_data_valid <= 1'b1;
                  r_update     <= 1'b1;
                  r_err_to     <= 1'b0;
                  r_err_cs     <= 1'b0;
                  r_state      <= ST_PUBLISH;
               end
            end
            ST_PUBLISH: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_dht_start    = r_start;
   assign o_hum_int      = r_hum_int;
   assign o_temp_int     = r_temp_int;
   assign o_hum_bcd      = r_hum_bcd;
   assign o_temp_bcd     = r_temp_bcd;
   assign o_data_valid   = r_data_valid;
   assign o_update       = r_update;
   assign o_err_timeout  = r_err_to;
   assign o_err_checksum = r_err_cs;
   assign o_err_cnt      = r_err_cnt;
   assign o_busy         = r_busy;
   assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_dht11_sequencer.sv
// Self-checking bench for dht11_sequencer (10 clocks per ms to keep saturation runs short).
module tb_dht11_sequencer;
   import dht11_sequencer_pkg::*;

   localparam int NV = 11;

   typedef struct {
      bit         valid;
      logic [7:0] h;
      logic [7:0] t;
      logic [11:0] hb;
      logic [11:0] tb;
   } vec_t;

   // ---------------- clock / reset / DUT ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic enable = 1'b0, force_req = 1'b0, dht_done = 1'b0, dht_valid = 1'b0;
   logic [15:0] dht_hum = '0, dht_temp = '0;
   logic        dht_start, data_valid, update, err_timeout, err_checksum, busy;
   logic [7:0]  hum_int, temp_int, err_cnt;
   logic [11:0] hum_bcd, temp_bcd;
   state_t      dbg_state;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [39:0] exp_q[$];
   int          lat_q[$];
   logic [7:0]  m_hum = '0, m_temp = '0, m_err = '0;
   bit          m_valid = 1'b0;
   vec_t        vec[NV];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dht11_sequencer #(
      .CLK_HZ(10_000), .POWERUP_MS(5), .PERIOD_MS(20), .MIN_GAP_MS(10), .TIMEOUT_MS(3)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_force_req(force_req),
      .i_dht_done(dht_done), .i_dht_valid(dht_valid),
      .i_dht_humidity(dht_hum), .i_dht_temperature(dht_temp),
      .o_dht_start(dht_start), .o_hum_int(hum_int), .o_temp_int(temp_int),
      .o_hum_bcd(hum_bcd), .o_temp_bcd(temp_bcd), .o_data_valid(data_valid),
      .o_update(update), .o_err_timeout(err_timeout), .o_err_checksum(err_checksum),
      .o_err_cnt(err_cnt), .o_busy(busy), .o_dbg_state(dbg_state)
   );

   // ---------------- checking helpers ----------------
   function automatic logic [11:0] bcd_of(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      n_tests++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // Scoreboard: every update pulse must match the oldest expected publish, 10 cycles after done.
   always @(negedge clk) begin
      if (!rst && update) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL spurious_update: got update=1 expected no update");
         end else begin
            check("publish", {hum_int, temp_int, hum_bcd, temp_bcd}, exp_q.pop_front());
            check_range("update_latency", cyc - lat_q.pop_front(), 10, 10);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_start(input int budget, output bit found, output int at);
      found = 1'b0;
      at    = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (dht_start) begin
            found = 1'b1;
            at    = cyc;
            break;
         end
      end
   endtask

   task automatic expect_start(input string name, input int budget, output int at);
      bit found;
      wait_start(budget, found, at);
      check(name, found, 1'b1);
   endtask

   task automatic do_frame(input bit valid, input logic [7:0] h, input logic [7:0] t,
                           input logic [11:0] hb, input logic [11:0] tb);
      dht_done  = 1'b1;
      dht_valid = valid;
      dht_hum   = {h, 8'($urandom_range(0, 255))};
      dht_temp  = {t, 8'($urandom_range(0, 255))};
      if (valid) begin
         exp_q.push_back({h, t, hb, tb});
         lat_q.push_back(cyc);
         m_hum   = h;
         m_temp  = t;
         m_valid = 1'b1;
      end else if (m_err != 8'hFF) begin
         m_err = m_err + 8'd1;
      end
      @(negedge clk);
      dht_done  = 1'b0;
      dht_valid = 1'b0;
   endtask

   task automatic pulse_force();
      force_req = 1'b1;
      @(negedge clk);
      force_req = 1'b0;
   endtask

   task automatic check_after(input bit exp_cs, input bit exp_to);
      tick(15);
      check("err_checksum", err_checksum, exp_cs);
      check("err_timeout", err_timeout, exp_to);
      check("err_cnt", err_cnt, m_err);
      check("data_valid", data_valid, m_valid);
      check("held_data", {hum_int, temp_int, hum_bcd, temp_bcd},
            {m_hum, m_temp, bcd_of(m_hum), bcd_of(m_temp)});
      check("busy_idle", busy, 1'b0);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int at, prev, t_rel, t_s, t_to, missing;
      bit found;
      logic [7:0] rh, rt;

      vec[0] = '{1'b1, 8'h37, 8'h1A, 12'h055, 12'h026};
      vec[1] = '{1'b0, 8'h50, 8'h50, 12'h000, 12'h000};
      vec[2] = '{1'b1, 8'd255, 8'd0, 12'h255, 12'h000};
      vec[3] = '{1'b1, 8'd99, 8'd100, 12'h099, 12'h100};
      vec[4] = '{1'b0, 8'd1, 8'd1, 12'h000, 12'h000};
      vec[5] = '{1'b1, 8'd9, 8'd10, 12'h009, 12'h010};
      vec[6] = '{1'b1, 8'd128, 8'd64, 12'h128, 12'h064};
      vec[7] = '{1'b1, 8'd200, 8'd199, 12'h200, 12'h199};
      for (int i = 8; i < NV; i++) begin
         rh = 8'($urandom_range(0, 255));
         rt = 8'($urandom_range(0, 255));
         vec[i] = '{1'b1, rh, rt, bcd_of(rh), bcd_of(rt)};
      end

      // Reset state
      rst = 1'b1;
      enable = 1'b1;
      tick(5);
      check("rst_data", {hum_int, temp_int, hum_bcd, temp_bcd}, 40'h0);
      check("rst_flags", {dht_start, data_valid, update, err_timeout, err_checksum, busy}, 6'b0);
      check("rst_err_cnt", err_cnt, 8'h00);
      check("rst_state", dbg_state, ST_POWERUP);

      // Power-up delay: first trigger 5 ms after reset release
      rst = 1'b0;
      t_rel = cyc;
      expect_start("powerup_start", 100, at);
      check_range("powerup_delay", at - t_rel, 48, 56);
      @(negedge clk);
      check("start_width", dht_start, 1'b0);
      prev = at;
      tick(2);

      // Table-driven frames on the automatic 20 ms cadence
      for (int i = 0; i < NV; i++) begin
         if (i > 0) begin
            expect_start("periodic_start", 250, at);
            check_range("period_spacing", at - prev, 195, 205);
            prev = at;
            tick(3);
         end
         do_frame(vec[i].valid, vec[i].h, vec[i].t, vec[i].hb, vec[i].tb);
         check_after(!vec[i].valid, 1'b0);
      end

      // Timeout: no response, then a late done that must be ignored
      expect_start("timeout_start", 250, at);
      check_range("period_spacing", at - prev, 195, 205);
      prev = at;
      t_s  = at;
      t_to = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (err_timeout) begin
            t_to = cyc;
            break;
         end
      end
      check_range("timeout_delay", t_to - t_s, 20, 32);
      if (m_err != 8'hFF) m_err = m_err + 8'd1;
      tick(2);
      dht_done = 1'b1;
      dht_valid = 1'b1;
      dht_hum = 16'h1100;
      dht_temp = 16'h2200;
      @(negedge clk);
      dht_done = 1'b0;
      dht_valid = 1'b0;
      check_after(1'b0, 1'b1);

      // Good frame clears the error flags; enable drops mid-transaction
      expect_start("recover_start", 250, at);
      check_range("period_spacing", at - prev, 195, 205);
      t_s = at;
      enable = 1'b0;
      tick(3);
      do_frame(1'b1, 8'd45, 8'd23, 12'h045, 12'h023);
      check_after(1'b0, 1'b0);

      // Force at 4 ms after a start is held until the 10 ms gap
      while (cyc < t_s + 40) @(negedge clk);
      pulse_force();
      expect_start("force_pend_start", 150, at);
      check_range("force_pend_delay", at - t_s, 95, 105);
      t_s = at;
      tick(3);
      do_frame(1'b1, 8'd60, 8'd30, 12'h060, 12'h030);
      check_after(1'b0, 1'b0);

      // Force at 12 ms after a start is honoured promptly
      while (cyc < t_s + 120) @(negedge clk);
      pulse_force();
      expect_start("force_now_start", 20, at);
      check_range("force_now_delay", at - (t_s + 120), 0, 12);
      tick(3);
      do_frame(1'b1, 8'd0, 8'd255, 12'h000, 12'h255);
      check_after(1'b0, 1'b0);

      // With enable low and nothing pending, no trigger occurs
      wait_start(300, found, at);
      check("no_auto_trigger", found, 1'b0);

      // Error counter saturation: push failed reads past 255
      missing = 0;
      for (int k = 0; k < 260; k++) begin
         pulse_force();
         wait_start(150, found, at);
         if (!found) missing++;
         tick(3);
         do_frame(1'b0, 8'hAA, 8'hBB, 12'h000, 12'h000);
      end
      check("sat_all_started", missing, 0);
      check_after(1'b1, 1'b0);
      check("err_cnt_sat", err_cnt, 8'hFF);

      // Reset while waiting for the controller abandons the transaction
      pulse_force();
      expect_start("rst_mid_start", 150, at);
      tick(2);
      check("wait_state", dbg_state, ST_WAIT_DONE);
      check("wait_busy", busy, 1'b1);
      rst = 1'b1;
      tick(2);
      check("rst2_data", {hum_int, temp_int, hum_bcd, temp_bcd}, 40'h0);
      check("rst2_flags", {dht_start, data_valid, update, err_timeout, err_checksum, busy}, 6'b0);
      check("rst2_err_cnt", err_cnt, 8'h00);
      check("rst2_state", dbg_state, ST_POWERUP);
      rst = 1'b0;
      tick(5);

      check("scoreboard_drained", 40'(exp_q.size()), 40'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
